// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
// Queue entries are packed as {pc, inst}, with the PC in the upper word.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INST_NOP             = 32'h0000_0013;
    localparam int          PC_W                 = 32;
    localparam int          INST_W               = 32;
    localparam int          QUEUE_ENTRY_W        = PC_W + INST_W;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: small FIFO of {pc, inst} entries between fetch and decode.
// Flush beats push and pop. The head reads as zero when the FIFO is empty.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [QUEUE_ENTRY_W-1:0]     push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [QUEUE_ENTRY_W-1:0]     head,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]                        wr_ptr_reg;
    logic [AW-1:0]                        rd_ptr_reg;
    logic [AW:0]                          count_reg;
    logic [DEPTH-1:0][QUEUE_ENTRY_W-1:0]  slots;
    logic                                 do_push;
    logic                                 do_pop;

    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [QUEUE_ENTRY_W-1:0] data_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
                    data_reg <= push_data;
                end
            end

            assign slots[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    assign head  = (count_reg != '0) ? slots[rd_ptr_reg] : '0;
    assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: keeps the PC, issues one read at a time and queues results for decode.
// FETCH_MISALIGN_CHECK_EN turns a misaligned redirect into a sticky fault instead of truncating.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int          QUEUE_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        inst_start,
    input  logic        inst_ready,
    output logic [31:0] i_addr,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    input  logic        jump_valid,
    input  logic [31:0] jump_addr,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        misalign
);

    localparam int              CW      = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(QUEUE_DEPTH);

    logic [31:0]              pc_reg;
    logic [31:0]              req_pc_reg;
    logic                     outstanding_reg;
    logic                     kill_reg;
    logic                     misalign_reg;
    logic [CW-1:0]            q_count;
    logic [QUEUE_ENTRY_W-1:0] q_head;
    logic                     jump_ok;
    logic [31:0]              jump_target;
    logic                     response;
    logic                     push;
    logic                     pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign jump_ok     = jump_valid && is_word_aligned(jump_addr);
    assign jump_target = jump_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_reg <= 1'b0;
        end else if (jump_valid) begin
            misalign_reg <= !jump_ok;
        end
    end
`else
    logic unused_jump_low;
    assign unused_jump_low = ^jump_addr[1:0];
    assign jump_ok         = jump_valid;
    assign jump_target     = {jump_addr[31:2], 2'b00};
    assign misalign_reg    = 1'b0;
`endif

    // Gated with rst_n so nothing is requested while reset is held.
    assign inst_start = rst_n && inst_ready && !outstanding_reg && !jump_valid
                        && (q_count < DEPTH_C) && !misalign_reg;
    assign response   = outstanding_reg && inst_valid;
    assign push       = response && !kill_reg && !jump_valid;
    assign pop        = id_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_VECTOR;
            req_pc_reg      <= RESET_VECTOR;
            outstanding_reg <= 1'b0;
            kill_reg        <= 1'b0;
        end else if (jump_valid) begin
            if (jump_ok) pc_reg <= jump_target;
            // A response landing in the redirect cycle is consumed here, so nothing is left to kill.
            outstanding_reg <= outstanding_reg && !inst_valid;
            kill_reg        <= outstanding_reg && !inst_valid;
        end else if (inst_start) begin
            pc_reg          <= pc_reg + 32'd4;
            req_pc_reg      <= pc_reg;
            outstanding_reg <= 1'b1;
        end else if (response) begin
            outstanding_reg <= 1'b0;
            kill_reg        <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data({req_pc_reg, inst}),
        .pop      (pop),
        .flush    (jump_valid),
        .head     (q_head),
        .count    (q_count)
    );

    assign i_addr   = pc_reg;
    assign id_valid = (q_count != '0);
    assign id_pc    = q_head[QUEUE_ENTRY_W-1:INST_W];
    assign id_inst  = q_head[INST_W-1:0];
    assign misalign = misalign_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand sequences for redirect/reset corners,
// then randomized traffic against a queue-based reference model with a latency-modelled memory.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_start;
    logic        inst_ready = 1'b0;
    logic [31:0] i_addr;
    logic [31:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst_start(inst_start),
        .inst_ready(inst_ready),
        .i_addr    (i_addr),
        .inst      (inst),
        .inst_valid(inst_valid),
        .jump_valid(jump_valid),
        .jump_addr (jump_addr),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_inst   (id_inst),
        .id_pc     (id_pc),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        vld;
        logic [31:0] word;
        logic        jv;
        logic [31:0] ja;
        logic        idr;
        logic        e_start;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rdy, input logic vld, input logic [31:0] word,
                                input logic jv, input logic [31:0] ja, input logic idr,
                                input logic e_start, input logic [31:0] e_addr, input logic e_idv,
                                input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.rdy = rdy; v.vld = vld; v.word = word; v.jv = jv; v.ja = ja; v.idr = idr;
        v.e_start = e_start; v.e_addr = e_addr; v.e_idv = e_idv; v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_start, input logic [31:0] e_addr,
                                 input logic e_idv, input logic [31:0] e_inst,
                                 input logic [31:0] e_pc, input logic e_mis);
        check({tag, ".inst_start"}, {31'd0, inst_start}, {31'd0, e_start});
        check({tag, ".i_addr"},     i_addr,               e_addr);
        check({tag, ".id_valid"},   {31'd0, id_valid},   {31'd0, e_idv});
        check({tag, ".id_inst"},    id_inst,              e_inst);
        check({tag, ".id_pc"},      id_pc,                e_pc);
        check({tag, ".misalign"},   {31'd0, misalign},   {31'd0, e_mis});
    endtask

    task automatic apply(input logic rdy, input logic vld, input logic [31:0] word,
                         input logic jv, input logic [31:0] ja, input logic idr);
        @(negedge clk);
        inst_ready = rdy; inst_valid = vld; inst = word;
        jump_valid = jv; jump_addr = ja; id_ready = idr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        inst_ready = 1'b0; inst_valid = 1'b0; inst = '0;
        jump_valid = 1'b0; jump_addr = '0; id_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    logic        m_busy;
    logic        m_kill;
    logic        m_mis;
    ent_t        m_q[$];

    // Memory model state
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_word;

    logic [31:0] after_pc;

    initial begin
        // Reset values, including inst_start held low while reset is asserted
        #1;
        inst_ready = 1'b1;
        #1;
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        inst_ready = 1'b0;
        rst_n = 1'b1;

        vecs.push_back(mk(1,0,32'h0,  0,32'h0,0, 1,32'h0,       0,32'h0, 32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,0, 0,32'h4,       0,32'h0, 32'h0));
        vecs.push_back(mk(1,1,32'h13, 0,32'h0,0, 0,32'h4,       0,32'h0, 32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,0, 1,32'h4,       1,32'h13,32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,0, 0,32'h8,       1,32'h13,32'h0));
        vecs.push_back(mk(1,1,32'h33, 0,32'h0,0, 0,32'h8,       1,32'h13,32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,0, 0,32'h8,       1,32'h13,32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,0, 0,32'h8,       1,32'h13,32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,1, 0,32'h8,       1,32'h13,32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,0, 1,32'h8,       1,32'h33,32'h4));
        vecs.push_back(mk(1,0,32'h0,  1,32'h100,0, 0,32'hC,     1,32'h33,32'h4));
        vecs.push_back(mk(1,1,32'h55, 0,32'h0,0, 0,32'h100,     0,32'h0, 32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,0, 1,32'h100,     0,32'h0, 32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,0, 0,32'h104,     0,32'h0, 32'h0));
        vecs.push_back(mk(1,1,32'h77, 1,32'h200,0, 0,32'h104,   0,32'h0, 32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,0, 1,32'h200,     0,32'h0, 32'h0));
        vecs.push_back(mk(1,1,32'h99, 0,32'h0,0, 0,32'h204,     0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,1, 0,32'h204,     1,32'h99,32'h200));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,0, 0,32'h204,     0,32'h0, 32'h0));
        vecs.push_back(mk(1,0,32'h0,  1,32'hFFFF_FFFC,0, 0,32'h204, 0,32'h0, 32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,0, 1,32'hFFFF_FFFC, 0,32'h0, 32'h0));
        vecs.push_back(mk(1,1,32'hAB, 0,32'h0,0, 0,32'h0,       0,32'h0, 32'h0));
        vecs.push_back(mk(1,0,32'h0,  0,32'h0,1, 1,32'h0,       1,32'hAB,32'hFFFF_FFFC));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,0, 0,32'h4,       0,32'h0, 32'h0));
        vecs.push_back(mk(0,1,32'h11, 0,32'h0,0, 0,32'h4,       0,32'h0, 32'h0));
        vecs.push_back(mk(0,0,32'h0,  0,32'h0,1, 0,32'h4,       1,32'h11,32'h0));

        foreach (vecs[i]) begin
            apply(vecs[i].rdy, vecs[i].vld, vecs[i].word, vecs[i].jv, vecs[i].ja, vecs[i].idr);
            $display("vec %0d start=%0b addr=%h id_valid=%0b id_inst=%h id_pc=%h",
                     i, inst_start, i_addr, id_valid, id_inst, id_pc);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_start, vecs[i].e_addr,
                          vecs[i].e_idv, vecs[i].e_inst, vecs[i].e_pc, 1'b0);
        end

`ifdef FETCH_MISALIGN_CHECK_EN
        apply(1, 0, 32'h0, 1, 32'h102, 0);
        check_outputs("mis_jump", 1'b0, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
        apply(1, 0, 32'h0, 0, 32'h0, 0);
        check_outputs("mis_stall1", 1'b0, 32'h4, 1'b0, 32'h0, 32'h0, 1'b1);
        apply(1, 0, 32'h0, 0, 32'h0, 0);
        check_outputs("mis_stall2", 1'b0, 32'h4, 1'b0, 32'h0, 32'h0, 1'b1);
        apply(1, 0, 32'h0, 1, 32'h200, 0);
        check_outputs("mis_clear_jump", 1'b0, 32'h4, 1'b0, 32'h0, 32'h0, 1'b1);
        apply(1, 0, 32'h0, 0, 32'h0, 0);
        check_outputs("mis_resume", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 1'b0);
        apply(0, 1, 32'h42, 0, 32'h0, 0);
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        check_outputs("mis_word", 1'b0, 32'h204, 1'b1, 32'h42, 32'h200, 1'b0);
        after_pc = 32'h204;
`else
        apply(1, 0, 32'h0, 1, 32'h102, 0);
        check_outputs("align_jump", 1'b0, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
        apply(1, 0, 32'h0, 0, 32'h0, 0);
        check_outputs("align_issue", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0);
        apply(0, 1, 32'h42, 0, 32'h0, 0);
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        check_outputs("align_word", 1'b0, 32'h104, 1'b1, 32'h42, 32'h100, 1'b0);
        after_pc = 32'h104;
`endif
        $display("redirect sequence done next_pc=%h", after_pc);

        // Reset asserted while a read is in flight
        apply(1, 0, 32'h0, 0, 32'h0, 0);
        check_outputs("mid_issue", 1'b1, after_pc, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        inst_ready = 1'b1; inst_valid = 1'b0; id_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_outputs("mid_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        inst_valid = 1'b1; inst = 32'hDEAD_BEEF;
        #1;
        check_outputs("mid_release", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        apply(0, 0, 32'h0, 0, 32'h0, 0);
        check_outputs("mid_no_stale", 1'b0, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
        apply(0, 1, 32'h13, 0, 32'h0, 0);
        apply(0, 0, 32'h0, 0, 32'h0, 1);
        check_outputs("mid_word", 1'b0, 32'h4, 1'b1, 32'h13, 32'h0, 1'b0);
        $display("mid-read reset sequence done");

        // Randomized traffic against the reference model
        do_reset();
        m_pc = 32'h0; m_req_pc = 32'h0; m_busy = 1'b0; m_kill = 1'b0; m_mis = 1'b0;
        m_q.delete();
        mem_busy = 1'b0; mem_cnt = 0; mem_word = '0;

        for (int c = 0; c < 3000; c++) begin
            logic        r, v, j, idr, e_start, resp;
            logic [31:0] w, ja;
            r   = ($urandom_range(0, 3) != 0);
            j   = ($urandom_range(0, 15) == 0);
            idr = ($urandom_range(0, 1) == 1);
            ja  = $urandom & 32'h0000_3FFF;
            if ($urandom_range(0, 3) != 0) ja[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) ja = {29'h1FFF_FFFF, ja[2:0]};
            w = $urandom;
            if (mem_busy && mem_cnt == 0) begin
                v = 1'b1; w = mem_word;
            end else if (!mem_busy) begin
                v = ($urandom_range(0, 7) == 0);
            end else begin
                v = 1'b0;
            end

            apply(r, v, w, j, ja, idr);

            e_start = r && !m_busy && !j && (m_q.size() < DEPTH) && !m_mis;
            check_outputs($sformatf("rnd%0d", c), e_start, m_pc, m_q.size() != 0,
                          (m_q.size() != 0) ? m_q[0].word : 32'h0,
                          (m_q.size() != 0) ? m_q[0].pc : 32'h0, m_mis);

            if (mem_busy && v) mem_busy = 1'b0;
            else if (mem_busy) mem_cnt--;
            if (inst_start) begin
                mem_busy = 1'b1; mem_cnt = $urandom_range(0, 3); mem_word = $urandom;
            end

            resp = m_busy && v;
            if (j) begin
                m_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
                if (ja[1:0] == 2'b00) begin
                    m_pc = ja; m_mis = 1'b0;
                end else begin
                    m_mis = 1'b1;
                end
`else
                m_pc = {ja[31:2], 2'b00};
`endif
                m_kill = m_busy && !v;
                m_busy = m_busy && !v;
                $display("rnd %0d jump addr=%h", c, ja);
            end else begin
                if (m_q.size() != 0 && idr) void'(m_q.pop_front());
                if (resp) begin
                    m_busy = 1'b0;
                    if (m_kill) begin
                        m_kill = 1'b0;
                    end else begin
                        m_q.push_back('{pc: m_req_pc, word: w});
                        $display("rnd %0d push pc=%h inst=%h", c, m_req_pc, w);
                    end
                end
                if (e_start) begin
                    m_busy = 1'b1; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
